// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// producing {remainder, quotient} for the HI/LO write port.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     dvd_q;
   logic [WIDTH-1:0]     dvs_q;
   logic [WIDTH:0]       rem_q;
   logic                 q_neg_q;
   logic                 r_neg_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 ready_q;

   logic                 op1_neg, op2_neg;
   logic [WIDTH-1:0]     op1_abs, op2_abs;
   logic [WIDTH+1:0]     trial, diff;
   logic [WIDTH:0]       rem_d;
   logic [WIDTH-1:0]     quo_d, quo_fix, rem_fix;

   always_comb begin
      op1_neg = signed_i & opdata1_i[WIDTH-1];
      op2_neg = signed_i & opdata2_i[WIDTH-1];
      op1_abs = op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
      op2_abs = op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

      // dvd_q shifts out dividend bits at the top and takes quotient bits at the bottom
      trial = {rem_q, dvd_q[WIDTH-1]};
      diff  = trial - {2'b00, dvs_q};
      if (diff[WIDTH+1]) begin
         rem_d = trial[WIDTH:0];
         quo_d = {dvd_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_d = diff[WIDTH:0];
         quo_d = {dvd_q[WIDTH-2:0], 1'b1};
      end

      quo_fix = q_neg_q ? (~quo_d + WIDTH'(1)) : quo_d;
      rem_fix = r_neg_q ? (~rem_d[WIDTH-1:0] + WIDTH'(1)) : rem_d[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i && !annul_i) begin
                  dvd_q   <= op1_abs;
                  dvs_q   <= op2_abs;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  q_neg_q <= op1_neg ^ op2_neg;
                  r_neg_q <= op1_neg;
                  if (opdata2_i == '0) begin
                     result_q <= {opdata1_i, {WIDTH{1'b1}}};
                     ready_q  <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (annul_i) begin
                  state_q <= IDLE;
               end else begin
                  dvd_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH-1)) begin
                     result_q <= {rem_fix, quo_fix};
                     ready_q  <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = (state_q != IDLE);

endmodule
